// File: rtl/hyper_pkg.sv
// Shared constants, hex encoder and FSM state type for the command-RAM dump/loader path.
// Pure definitions: no latency, no flow control.
package hyper_pkg;

  localparam int DIVIDER_DEFAULT = 19999;

  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_COLON = 8'h3A;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_NEXT
  } dump_state_t;

  // Uppercase only, so HyperTerminal output matches the loader's input format.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
    return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, LSB first, DIVIDER+1 clk_48 cycles per bit.
// Latency: tx drops to the start bit on the edge that accepts valid && ready.
// ready is high when idle and in the last stop-bit cycle, so frames can abut.
module uart_tx_byte
  import hyper_pkg::*;
#(
  parameter int DIVIDER = DIVIDER_DEFAULT
) (
  input  logic       clk_48,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int DW = (DIVIDER < 1) ? 1 : $clog2(DIVIDER + 1);

  logic          r_busy;
  logic          r_tx;
  logic [8:0]    r_shift;
  logic [3:0]    r_bit;
  logic [DW-1:0] r_div;
  logic          w_bit_end;
  logic          w_load;

  assign w_bit_end = (r_div == DW'(DIVIDER));
  assign ready     = !r_busy || (w_bit_end && (r_bit == 4'd9));
  assign w_load    = valid && ready;
  assign tx        = r_tx;

  // r_shift holds the bits still to go out after the start bit; its MSB is the stop bit.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_shift <= '1;
      r_bit   <= '0;
      r_div   <= '0;
    end else if (w_load) begin
      r_busy  <= 1'b1;
      r_tx    <= 1'b0;
      r_shift <= {1'b1, data};
      r_bit   <= '0;
      r_div   <= '0;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_div <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyper_dump.sv
// hyper_dump: sends RAM words 0..last_addr as "ABCD\r\n" lines; HYPER_DUMP_ADDR_EN adds an "AAA: " prefix.
// Latency: start sampled -> start bit 3 cycles; line period chars*10*(DIVIDER+1)+3 cycles.
// No backpressure: start is only taken in IDLE, requests while busy are dropped.
module hyper_dump
  import hyper_pkg::*;
#(
  parameter int DIVIDER = DIVIDER_DEFAULT,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
) (
  input  logic              clk_48,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_word;
  logic [3:0]        r_idx;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        w_char;
  logic              w_valid;
  logic              w_ready;

`ifdef HYPER_DUMP_ADDR_EN
  localparam logic [3:0] LAST_IDX = 4'd10;
  logic [11:0] w_addr12;
  assign w_addr12 = {2'b00, r_addr[9:0]};
`else
  localparam logic [3:0] LAST_IDX = 4'd5;
`endif

  always_comb begin
    w_char = CHR_LF;
    case (r_idx)
`ifdef HYPER_DUMP_ADDR_EN
      4'd0:    w_char = hex2ascii(w_addr12[11:8]);
      4'd1:    w_char = hex2ascii(w_addr12[7:4]);
      4'd2:    w_char = hex2ascii(w_addr12[3:0]);
      4'd3:    w_char = CHR_COLON;
      4'd4:    w_char = CHR_SPACE;
      4'd5:    w_char = hex2ascii(r_word[15:12]);
      4'd6:    w_char = hex2ascii(r_word[11:8]);
      4'd7:    w_char = hex2ascii(r_word[7:4]);
      4'd8:    w_char = hex2ascii(r_word[3:0]);
      4'd9:    w_char = CHR_CR;
`else
      4'd0:    w_char = hex2ascii(r_word[15:12]);
      4'd1:    w_char = hex2ascii(r_word[11:8]);
      4'd2:    w_char = hex2ascii(r_word[7:4]);
      4'd3:    w_char = hex2ascii(r_word[3:0]);
      4'd4:    w_char = CHR_CR;
`endif
      default: w_char = CHR_LF;
    endcase
  end

  assign w_valid = (r_state == ST_SEND);

  // NEXT overlaps the LF frame and acts on its last stop-bit cycle, keeping the inter-line gap at 3 cycles.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_last  <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_last  <= last_addr;
            r_addr  <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_word  <= rd_data;
          r_idx   <= '0;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_ready) begin
            if (r_idx == LAST_IDX) r_state <= ST_NEXT;
            else r_idx <= r_idx + 4'd1;
          end
        end
        ST_NEXT: begin
          if (w_ready) begin
            if (r_addr == r_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .DIVIDER (DIVIDER)
  ) u_tx (
    .clk_48 (clk_48),
    .rst    (rst),
    .data   (w_char),
    .valid  (w_valid),
    .ready  (w_ready),
    .tx     (tx)
  );

  assign addr = r_addr;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_hyper_dump.sv
// Bench for hyper_dump: instance A (DIVIDER=3) for directed line checks, instance B (DIVIDER=0) for the full-RAM dump.
module tb_hyper_dump;

`ifdef HYPER_DUMP_ADDR_EN
  localparam int LEN = 11;
  localparam int PFX = 5;
`else
  localparam int LEN = 6;
  localparam int PFX = 0;
`endif

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         t;
    logic [9:0] a;
  } rx_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;

  logic        rst_a, start_a, tx_a, busy_a, done_a;
  logic [9:0]  last_a, addr_a;
  logic [15:0] rd_a;
  logic [15:0] ram_a [0:1023];

  logic        rst_b, start_b, tx_b, busy_b, done_b;
  logic [9:0]  last_b, addr_b, addr_b_prev;
  logic [15:0] rd_b;
  logic [15:0] ram_b [0:1023];

  rx_t         rxq[$];
  logic [7:0]  qb[$];
  int          dcnt_a = 0, dcyc_a = 0, dcnt_b = 0, nchg_b = 0, badstop_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_a <= ram_a[addr_a];
  always @(posedge clk) rd_b <= ram_b[addr_b];

  hyper_dump #(.DIVIDER(3), .ADDR_W(10), .DATA_W(16)) u_dut_a (
    .clk_48(clk), .rst(rst_a), .start(start_a), .last_addr(last_a), .addr(addr_a),
    .rd_data(rd_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  hyper_dump #(.DIVIDER(0), .ADDR_W(10), .DATA_W(16)) u_dut_b (
    .clk_48(clk), .rst(rst_b), .start(start_b), .last_addr(last_b), .addr(addr_b),
    .rd_data(rd_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  // 8N1 receiver for A: 4 cycles per bit, sampled mid-cycle on negedges.
  always begin
    @(negedge clk);
    if (!rst_a && tx_a === 1'b0) begin
      rx_t r;
      r.t = cyc;
      r.a = addr_a;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        r.b[i] = tx_a;
      end
      repeat (4) @(negedge clk);
      r.stop = tx_a;
      rxq.push_back(r);
    end
  end

  always begin
    @(negedge clk);
    if (!rst_b && tx_b === 1'b0) begin
      logic [7:0] v;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        v[i] = tx_b;
      end
      @(negedge clk);
      if (tx_b !== 1'b1) badstop_b++;
      qb.push_back(v);
    end
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      dcnt_a++;
      dcyc_a = cyc;
    end
    if (done_b === 1'b1) dcnt_b++;
    if (addr_b != addr_b_prev) nchg_b++;
    addr_b_prev = addr_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [9:0] a, input logic [15:0] w, input int k);
    string      hx = "0123456789ABCDEF";
    logic [11:0] a12 = {2'b00, a};
    int         j = k - PFX;
    if (j < 0) begin
      if (k < 3) return hx[a12[11-4*k -: 4]];
      if (k == 3) return 8'h3A;
      return 8'h20;
    end
    if (j < 4) return hx[w[15-4*j -: 4]];
    return (j == 4) ? 8'h0D : 8'h0A;
  endfunction

  task automatic check_line(input string tag, input int i0, input logic [9:0] a, input logic [15:0] w);
    if (rxq.size() < i0 + LEN) begin
      chk({tag, "_short"}, rxq.size(), i0 + LEN);
      return;
    end
    for (int k = 0; k < LEN; k++) begin
      chk({tag, "_chr"}, rxq[i0+k].b, exp_byte(a, w, k));
      chk({tag, "_stop"}, rxq[i0+k].stop, 1);
      chk({tag, "_addr"}, rxq[i0+k].a, a);
      if (k > 0) chk({tag, "_gap"}, rxq[i0+k].t - rxq[i0+k-1].t, 40);
    end
  endtask

  task automatic go_a(input logic [9:0] la, output int c0);
    @(negedge clk);
    last_a  = la;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_idle_a(input string tag, input int max);
    int n = 0;
    while (busy_a && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, busy_a, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_a;
    int c0;
    logic [7:0] t1 [0:5];
    t1 = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};

    // Single word, last_addr = 0.
    ram_a[0] = 16'h1A2F;
    rxq.delete(); dcnt_a = 0;
    go_a(10'd0, c0);
    chk("t1_busy_hi", busy_a, 1);
    wait_idle_a("t1", 4000);
    chk("t1_nfr", rxq.size(), LEN);
    if (rxq.size() >= LEN) begin
      chk("t1_lat", rxq[0].t - c0, 3);
      for (int k = 0; k < 6; k++) chk("t1_lit", rxq[PFX+k].b, t1[k]);
      chk("t1_done_t", dcyc_a - rxq[LEN-1].t, 40);
    end
    check_line("t1", 0, 10'd0, 16'h1A2F);
    chk("t1_done", dcnt_a, 1);

    // Three words including all-zero and all-ones nibbles.
    ram_a[0] = 16'h0000; ram_a[1] = 16'hFFFF; ram_a[2] = 16'hBEEF;
    rxq.delete(); dcnt_a = 0;
    go_a(10'd2, c0);
    wait_idle_a("t2", 4000);
    chk("t2_nfr", rxq.size(), 3 * LEN);
    check_line("t2l0", 0, 10'd0, 16'h0000);
    check_line("t2l1", LEN, 10'd1, 16'hFFFF);
    check_line("t2l2", 2 * LEN, 10'd2, 16'hBEEF);
    if (rxq.size() >= 2 * LEN) chk("t2_line_t", rxq[LEN].t - rxq[0].t, LEN * 40 + 3);
    chk("t2_done", dcnt_a, 1);
    chk("t2_addr", addr_a, 2);

    // Second start mid-dump with a larger last_addr is dropped.
    ram_a[0] = 16'h1234; ram_a[1] = 16'h5678; ram_a[2] = 16'h9ABC; ram_a[3] = 16'hDEF0;
    rxq.delete(); dcnt_a = 0;
    go_a(10'd1, c0);
    repeat (100) @(negedge clk);
    go_a(10'd3, c0);
    wait_idle_a("t3", 4000);
    chk("t3_nfr", rxq.size(), 2 * LEN);
    check_line("t3l1", LEN, 10'd1, 16'h5678);
    chk("t3_done", dcnt_a, 1);
    chk("t3_addr", addr_a, 1);

    // Reset in the third bit of the first frame of line 1.
    rxq.delete(); dcnt_a = 0;
    go_a(10'd1, c0);
    while (cyc < c0 + 3 + LEN * 40 + 3 + 9) @(negedge clk);
    chk("t4_pre_addr", addr_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("t4_tx", tx_a, 1);
    chk("t4_busy", busy_a, 0);
    chk("t4_addr", addr_a, 0);
    chk("t4_done", done_a, 0);
    rst_a = 1'b0;
    repeat (60) @(negedge clk);
    chk("t4_quiet", tx_a, 1);
    chk("t4_nodone", dcnt_a, 0);
    ram_a[0] = 16'hC0DE;
    rxq.delete(); dcnt_a = 0;
    go_a(10'd0, c0);
    wait_idle_a("t4b", 4000);
    chk("t4b_nfr", rxq.size(), LEN);
    if (rxq.size() > 0) chk("t4b_lat", rxq[0].t - c0, 3);
    check_line("t4b", 0, 10'd0, 16'hC0DE);
    chk("t4b_done", dcnt_a, 1);

`ifdef HYPER_DUMP_ADDR_EN
    begin
      logic [7:0] t6 [0:10];
      t6 = '{8'h30, 8'h30, 8'h35, 8'h3A, 8'h20, 8'h30, 8'h30, 8'h43, 8'h33, 8'h0D, 8'h0A};
      ram_a[4] = 16'h4444; ram_a[5] = 16'h00C3;
      rxq.delete(); dcnt_a = 0;
      go_a(10'd5, c0);
      wait_idle_a("t6", 8000);
      chk("t6_nfr", rxq.size(), 66);
      if (rxq.size() >= 66) for (int k = 0; k < 11; k++) chk("t6_lit", rxq[55+k].b, t6[k]);
      check_line("t6", 55, 10'd5, 16'h00C3);
    end
`endif
  endtask

  task automatic run_b;
    int n = 0;
    nchg_b = 0; dcnt_b = 0;
    @(negedge clk);
    last_b  = 10'h3FF;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (busy_b && n < 130000) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle", busy_b, 0);
    repeat (20) @(negedge clk);
    chk("b_bytes", qb.size(), 1024 * LEN);
    chk("b_badstop", badstop_b, 0);
    chk("b_done", dcnt_b, 1);
    chk("b_addr_steps", nchg_b, 1023);
    chk("b_addr_hold", addr_b, 10'h3FF);
    chk("b_tx_idle", tx_b, 1);
    if (qb.size() >= 1024 * LEN)
      for (int k = 0; k < LEN; k++) chk("b_last_line", qb[1023*LEN+k], exp_byte(10'h3FF, ram_b[1023], k));
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; last_a = '0;
    rst_b = 1'b1; start_b = 1'b0; last_b = '0;
    for (int i = 0; i < 1024; i++) begin
      ram_a[i] = 16'h0000;
      ram_b[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
    end
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_tx_b", tx_b, 1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    fork
      run_a();
      run_b();
    join
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/hyper_dump.md
# hyper_dump

Serial memory dump transmitter for the HERA command-RAM loader path. On a start pulse it reads command RAM words from address 0 to a given last address and sends each word over the null-modem TX line as four uppercase ASCII hex characters followed by CR LF, for display in HyperTerminal. It uses the same 8N1 frame format that the command loader receives, so an operator can verify loaded programs.

## Interface
Parameters:
- DIVIDER, 19999: clk_48 cycles per serial bit minus 1. The default gives 2400 bps at 48 MHz.
- ADDR_W, 10: RAM address width.
- DATA_W, 16: RAM word width. Fixed at 16; four hex digits are emitted per word.

Ports:
- clk_48  in  1: the single clock. All logic is on posedge.
- rst  in  1: reset, synchronous, active-high.
- start  in  1: one-cycle request to begin a dump. It is only accepted in IDLE.
- last_addr  in  ADDR_W: last address to dump, inclusive. Latched when start is accepted.
- addr  out  ADDR_W: RAM read address.
- rd_data  in  DATA_W: RAM read data, valid 1 cycle after addr changes.
- tx  out  1: serial line. Idle level is 1.
- busy  out  1: high from start acceptance until done.
- done  out  1: one-cycle pulse after the final LF stop bit.

## Operation
- Frame format: 8N1, LSB first.
  - Start bit is 0, then 8 data bits, then stop bit 1.
  - Each bit is held for DIVIDER+1 cycles.
- Reset values: tx=1, busy=0, done=0, addr=0. FSM is in IDLE, the bit counter is 0, and the divider counter is 0.
- FSM states:
  - IDLE: waits for start. When start is accepted it sets busy=1, latches last_addr, sets addr=0, and goes to FETCH.
  - FETCH: a 1-cycle wait for RAM latency, then goes to LATCH.
  - LATCH: captures rd_data into word_q, sets char index=0, and goes to SEND.
  - SEND: presents char[idx] to the serializer.
    - The character order is hex(word_q[15:12]), [11:8], [7:4], [3:0], then 8'h0D, then 8'h0A.
    - idx advances on each serializer accept.
    - After LF is accepted and its frame has completed, the FSM goes to NEXT.
  - NEXT: if addr==last_addr, it pulses done, clears busy, and returns to IDLE. Otherwise addr increments by 1 and the FSM goes to FETCH.
- Hex encoding: nibbles 0–9 map to 8'h30–8'h39, and nibbles A–F map to 8'h41–8'h46 (uppercase only).
- Boundaries:
  - last_addr=0 dumps exactly one word.
  - last_addr=2^ADDR_W−1 dumps the whole RAM, and addr does not wrap past it. addr stays at last_addr in IDLE.
- start while busy is ignored. The last_addr latch is not disturbed.
- rst mid-frame: tx=1 on the next cycle and all state returns to reset values. No partial frame is completed.
- The rd_data value is only sampled in LATCH, so RAM writes during a dump only affect words not yet fetched.

## Timing
- start sampled at edge 0 → addr=0 at edge 1, word latched at edge 2, tx falls (start bit) at edge 3.
- Characters within a line are sent back-to-back, with no idle gap between stop bit and next start bit.
- Between lines there is a 2-cycle gap (NEXT + FETCH) plus the LATCH cycle, during which tx=1.
- Line time is 6×10×(DIVIDER+1) + 3 cycles without HYPER_DUMP_ADDR_EN, and 11×10×(DIVIDER+1) + 3 cycles with it.
- done is asserted on the cycle after the LF stop-bit period ends. busy falls on that same edge.

## Configuration
- HYPER_DUMP_ADDR_EN defined: each line is prefixed with the address. The address is always emitted as three uppercase hex digits of addr[9:0] (addr[11:10] are zero), followed by ':' (8'h3A) and ' ' (8'h20). Lines are 11 characters, e.g. "03F: ABCD\r\n".
- HYPER_DUMP_ADDR_EN undefined: lines are 6 characters ("ABCD\r\n"), and no address logic is synthesized.

## Structure
- Package hyper_pkg holds:
  - ASCII constants CHR_CR, CHR_LF, CHR_COLON, CHR_SPACE;
  - function hex2ascii(nibble);
  - state enum dump_state_t;
  - the default DIVIDER value, shared with the loader.
- Sub-module uart_tx_byte: the 8N1 serializer.
  - Ports: clk_48, rst, data[7:0], valid, ready, tx. Parameter DIVIDER.
  - ready is high in idle and during the last cycle of the stop bit, which makes back-to-back frames possible.
  - The top-level FSM only sequences characters and addresses.

## Test plan
- DIVIDER=3, RAM[0]=16'h1A2F, last_addr=0, pulse start → tx carries 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A, 40 cycles per frame; one done pulse; busy low afterwards.
- RAM[0..2]=16'h0000, 16'hFFFF, 16'hBEEF, last_addr=2 → lines "0000", "FFFF", "BEEF"; addr sequence 0,1,2; exactly one done.
- start re-pulsed mid-dump with a different last_addr → ignored; dump ends at the original last_addr.
- rst asserted in the middle of the third bit of a frame → next cycle tx=1, busy=0, addr=0; a new start then begins cleanly from address 0.
- last_addr=10'h3FF with a small RAM model → 1024 lines; the final line is addr 3FF; addr holds 3FF with no wrap.
- With HYPER_DUMP_ADDR_EN, RAM[5]=16'h00C3, last_addr=5 → sixth line is "005: 00C3\r\n" (11 frames).
